// File: rtl/ast_itrace_ctrl.sv
// Instruction-trace capture: {stamp, IR} into a circular buffer, frozen by opcode trigger or stop.
// Capture takes one cycle per IR_valid; readout is a combinational async-read that holds while rd_ready is low.
module ast_itrace_ctrl #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int POST_CNT = 8
) (
    input  logic          Clock_pin,
    input  logic          Resetn_pin,
    input  logic [15:0]   IR,
    input  logic          IR_valid,
    input  logic          arm,
    input  logic          stop,
    input  logic          trig_en,
    input  logic [5:0]    trig_opcode,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [23:0]   rd_data,
    output logic [1:0]    state,
    output logic          triggered,
    output logic          overflow,
    output logic [AW:0]   count
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        POST  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_CNT);

    state_t          state_q;
    logic [AW-1:0]   wptr_q, rptr_q, post_ctr_q;
    logic [AW:0]     count_q;
    logic [7:0]      stamp_q;
    logic            triggered_q, overflow_q;
    logic [23:0]     mem [DEPTH];

    logic capturing, wr_en, trig_hit, rd_fire;

    assign capturing = (state_q == ARMED) || (state_q == POST);
    assign wr_en     = capturing && IR_valid && !arm;
    assign trig_hit  = (state_q == ARMED) && trig_en && IR_valid && (IR[13:8] == trig_opcode);
    assign rd_fire   = (state_q == DONE) && (count_q != '0) && rd_ready;

    always_ff @(posedge Clock_pin) begin
        if (wr_en) mem[wptr_q] <= {stamp_q, IR};
    end

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            post_ctr_q  <= '0;
            count_q     <= '0;
            stamp_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (arm) begin
            state_q     <= ARMED;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            stamp_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (capturing) stamp_q <= stamp_q + 8'd1;
            // A write into a full buffer drops the oldest entry.
            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
                if (count_q == FULL) begin
                    rptr_q     <= rptr_q + 1'b1;
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
            if (rd_fire) begin
                rptr_q  <= rptr_q + 1'b1;
                count_q <= count_q - 1'b1;
            end
            case (state_q)
                ARMED: begin
                    if (trig_hit) begin
                        triggered_q <= 1'b1;
                        post_ctr_q  <= POST_INIT;
                        state_q     <= (POST_CNT == 0) ? DONE : POST;
                    end else if (stop) begin
                        state_q <= DONE;
                    end
                end
                POST: begin
                    if (IR_valid) begin
                        post_ctr_q <= post_ctr_q - 1'b1;
                        if (post_ctr_q == AW'(1)) state_q <= DONE;
                    end
                    if (stop) state_q <= DONE;
                end
                default: ;
            endcase
        end
    end

    assign rd_valid  = (state_q == DONE) && (count_q != '0);
    assign rd_data   = (state_q == DONE) ? mem[rptr_q] : 24'h0;
    assign state     = state_q;
    assign triggered = triggered_q;
    assign overflow  = overflow_q;
    assign count     = count_q;
endmodule
